viterbi_decoder_k3: RTL and testbench

Hard-decision Viterbi decoder for the team's rate-1/2, K=3 convolutional code with generators g1=110, g2=111. Code equations per input bit u_n: p0 = u_n ^ u_{n-1}; p1 = u_n ^ u_{n-1} ^ u_{n-2}. The block sits at the receive end of the link. It accepts one 2-bit parity symbol per valid cycle and emits the maximum-likelihood input bit with a fixed latency of D symbols, using register-exchange survivors.

---
 rtl/viterbi_decoder_k3_pkg.sv | 23 ++
 rtl/viterbi_decoder_k3_if.sv | 12 +
 rtl/viterbi_acs_k3.sv | 23 ++
 rtl/viterbi_decoder_k3.sv | 123 ++++++++++++
 tb/tb_viterbi_decoder_k3.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/viterbi_decoder_k3_pkg.sv
// rtl/viterbi_decoder_k3_pkg.sv - shared constants, state type and trellis helpers for the K=3 decoder
package viterbi_decoder_k3_pkg;

  localparam logic [2:0] G1 = 3'b110;
  localparam logic [2:0] G2 = 3'b111;

  // {u_{n-1}, u_{n-2}}, newest bit in the MSB
  typedef logic [1:0] state_t;

  // Encoder output {p1, p0} when input u leaves state s
  function automatic logic [1:0] expected_sym(input state_t s, input logic u);
    logic [2:0] taps;
    taps = {u, s};
    return {^(taps & G2), ^(taps & G1)};
  endfunction

  function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {x[1] & x[0], x[1] ^ x[0]};
  endfunction

endpackage

// File: rtl/viterbi_decoder_k3_if.sv
// rtl/viterbi_decoder_k3_if.sv - symbol-in / decoded-bit-out bundle for the K=3 decoder
interface viterbi_decoder_k3_if #(parameter int MW = 6);
  logic          clear;
  logic          in_valid;
  logic [1:0]    sym;
  logic          out_valid;
  logic          out_bit;
  logic [MW-1:0] best_metric;

  modport master (output clear, in_valid, sym, input out_valid, out_bit, best_metric);
  modport slave  (input clear, in_valid, sym, output out_valid, out_bit, best_metric);
endinterface

// File: rtl/viterbi_acs_k3.sv
// rtl/viterbi_acs_k3.sv - one add-compare-select butterfly half for the K=3 trellis
module viterbi_acs_k3 #(
  parameter int MW = 6
) (
  input  logic [MW-1:0] metric0_i,
  input  logic [MW-1:0] metric1_i,
  input  logic [1:0]    bm0_i,
  input  logic [1:0]    bm1_i,
  output logic [MW-1:0] metric_o,
  output logic          dec_o,
  output logic          ovf_o
);
  logic [MW:0] sum0, sum1;

  always_comb begin
    sum0 = {1'b0, metric0_i} + {{(MW-1){1'b0}}, bm0_i};
    sum1 = {1'b0, metric1_i} + {{(MW-1){1'b0}}, bm1_i};
    // Strict compare: a tie keeps the b=0 predecessor
    dec_o    = (sum1 < sum0);
    metric_o = dec_o ? sum1[MW-1:0] : sum0[MW-1:0];
    ovf_o    = dec_o ? sum1[MW] : sum0[MW];
  end
endmodule

// File: rtl/viterbi_decoder_k3.sv
// rtl/viterbi_decoder_k3.sv - hard-decision register-exchange Viterbi decoder, rate 1/2, K=3
module viterbi_decoder_k3
  import viterbi_decoder_k3_pkg::*;
#(
  parameter int D  = 15,
  parameter int MW = 6
) (
  input logic                  CLK,
  input logic                  RST_N,
  viterbi_decoder_k3_if.slave  bus
);
  localparam int            CW      = $clog2(D + 1);
  localparam logic [CW-1:0] FILL_MAX = CW'(D);
  localparam logic [MW-1:0] INIT_HI = {1'b0, {(MW-1){1'b1}}};

  logic [MW-1:0] metric_q [4];
  logic [MW-1:0] metric_d [4];
  logic [MW-1:0] acs_m [4];
  logic [MW-1:0] metric_new [4];
  logic [D-1:0]  surv_q [4];
  logic [D-1:0]  surv_d [4];
  logic [D-1:0]  surv_new [4];
  logic          dec [4];
  logic          ovf [4];
  logic [CW-1:0] fill_q, fill_d;
  logic          out_valid_q, out_valid_d;
  logic          out_bit_q, out_bit_d;
  logic [MW-1:0] best_metric_q, best_metric_d;
  logic          norm;
  state_t        best_cur, best_new;

  for (genvar ns = 0; ns < 4; ns++) begin : g_acs
    localparam state_t NS = state_t'(ns);
    localparam state_t P0 = {NS[0], 1'b0};
    localparam state_t P1 = {NS[0], 1'b1};
    logic [1:0] bm0, bm1;

    assign bm0 = hamming2(bus.sym, expected_sym(P0, NS[1]));
    assign bm1 = hamming2(bus.sym, expected_sym(P1, NS[1]));

    viterbi_acs_k3 #(.MW(MW)) u_acs (
      .metric0_i (metric_q[P0]),
      .metric1_i (metric_q[P1]),
      .bm0_i     (bm0),
      .bm1_i     (bm1),
      .metric_o  (acs_m[ns]),
      .dec_o     (dec[ns]),
      .ovf_o     (ovf[ns])
    );

    assign surv_new[ns] = dec[ns] ? {surv_q[P1][D-2:0], NS[1]} : {surv_q[P0][D-2:0], NS[1]};
  end

  // Clearing the MSB is the subtraction of 2^(MW-1) once every metric has it set
  always_comb begin
    norm = 1'b1;
    for (int i = 0; i < 4; i++) norm = norm & acs_m[i][MW-1];
    for (int i = 0; i < 4; i++) metric_new[i] = norm ? {1'b0, acs_m[i][MW-2:0]} : acs_m[i];
  end

  always_comb begin
    best_cur = '0;
    best_new = '0;
    for (int i = 1; i < 4; i++) begin
      if (metric_q[i] < metric_q[best_cur])     best_cur = state_t'(i);
      if (metric_new[i] < metric_new[best_new]) best_new = state_t'(i);
    end
  end

  always_comb begin
    metric_d      = metric_q;
    surv_d        = surv_q;
    fill_d        = fill_q;
    out_valid_d   = 1'b0;
    out_bit_d     = out_bit_q;
    best_metric_d = best_metric_q;
    if (bus.clear) begin
      metric_d[0] = '0;
      for (int i = 1; i < 4; i++) metric_d[i] = INIT_HI;
      for (int i = 0; i < 4; i++) surv_d[i] = '0;
      fill_d        = '0;
      best_metric_d = '0;
    end else if (bus.in_valid) begin
      metric_d      = metric_new;
      surv_d        = surv_new;
      best_metric_d = metric_new[best_new];
      if (fill_q == FILL_MAX) begin
        out_valid_d = 1'b1;
        out_bit_d   = surv_q[best_cur][D-1];
      end else begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      metric_q[0] <= '0;
      for (int i = 1; i < 4; i++) metric_q[i] <= INIT_HI;
      for (int i = 0; i < 4; i++) surv_q[i] <= '0;
      fill_q        <= '0;
      out_valid_q   <= 1'b0;
      out_bit_q     <= 1'b0;
      best_metric_q <= '0;
    end else begin
      metric_q      <= metric_d;
      surv_q        <= surv_d;
      fill_q        <= fill_d;
      out_valid_q   <= out_valid_d;
      out_bit_q     <= out_bit_d;
      best_metric_q <= best_metric_d;
    end
  end

  always @(posedge CLK) begin
    if (RST_N && bus.in_valid && !bus.clear)
      assert (!(ovf[0] | ovf[1] | ovf[2] | ovf[3]));
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_bit     = out_bit_q;
  assign bus.best_metric = best_metric_q;
endmodule

// File: tb/tb_viterbi_decoder_k3.sv
// tb/tb_viterbi_decoder_k3.sv - scoreboard bench for viterbi_decoder_k3
module tb_viterbi_decoder_k3;
  localparam int D  = 15;
  localparam int MW = 6;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  viterbi_decoder_k3_if #(.MW(MW)) bus ();

  viterbi_decoder_k3 #(.D(D), .MW(MW)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  int          errors = 0;
  int          checks = 0;
  bit          exp_q[$];
  logic [1:0]  enc_mem = 2'b00;
  int          acc = 0;
  logic [MW-1:0] prev_best = '0;
  bit          saw_norm = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [1:0] encode(input logic u, input logic [1:0] m);
    logic p0, p1;
    p0 = u ^ m[1];
    p1 = u ^ m[1] ^ m[0];
    return {p1, p0};
  endfunction

  task automatic reset_model();
    exp_q.delete();
    acc       = 0;
    enc_mem   = 2'b00;
    prev_best = '0;
  endtask

  // One clock: drive, clock, then score the outputs of that edge
  task automatic step(input bit v, input bit u, input logic [1:0] flip, input bit clr, input int exp_best);
    logic [1:0] s;
    bit accepted, want_out, eb;
    s = encode(u, enc_mem) ^ flip;
    if (!v) s = 2'($urandom_range(0, 3));
    accepted = v && !clr;
    want_out = accepted && (acc >= D);
    bus.in_valid = v;
    bus.sym      = s;
    bus.clear    = clr;
    @(posedge CLK);
    #1;
    if (clr) begin
      reset_model();
    end else if (v) begin
      exp_q.push_back(u);
      enc_mem = {u, enc_mem[1]};
      acc++;
    end
    check_val("out_valid", bus.out_valid, want_out);
    if (bus.out_valid === 1'b1) begin
      eb = 1'bx;
      if (exp_q.size() > 0) eb = exp_q.pop_front();
      check_val("out_bit", bus.out_bit, eb);
    end
    if (accepted) begin
      if (exp_best >= 0) check_val("best_metric", bus.best_metric, exp_best);
      if (bus.best_metric < prev_best) saw_norm = 1'b1;
      prev_best = bus.best_metric;
    end
    bus.in_valid = 1'b0;
    bus.clear    = 1'b0;
  endtask

  task automatic send_frame(input bit bits[$], input int err_sym, input logic [1:0] err_mask,
                            input bit gaps, input bit chk_best);
    for (int i = 0; i < bits.size(); i++) begin
      if (gaps) step(1'b0, 1'b0, 2'b00, 1'b0, -1);
      step(1'b1, bits[i], (i == err_sym) ? err_mask : 2'b00, 1'b0,
           !chk_best ? -1 : ((err_sym >= 0 && i >= err_sym) ? 1 : 0));
    end
  endtask

  task automatic do_clear();
    step(1'b0, 1'b0, 2'b00, 1'b1, -1);
  endtask

  initial begin
    bit f1[$];
    bit f2[$];
    bit lr[$];
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    bus.sym      = 2'b00;

    @(posedge CLK);
    #1;
    check_val("rst_out_valid", bus.out_valid, 0);
    check_val("rst_out_bit", bus.out_bit, 0);
    check_val("rst_best_metric", bus.best_metric, 0);
    @(negedge CLK);
    RST_N = 1'b1;

    f1 = '{1, 0, 1, 1, 0, 0, 0};
    repeat (D) f1.push_back(1'b0);
    f2 = '{0, 1, 1, 0, 1, 0, 0};
    repeat (D) f2.push_back(1'b0);

    send_frame(f1, -1, 2'b00, 1'b0, 1'b1);
    do_clear();
    send_frame(f1, 2, 2'b10, 1'b0, 1'b1);
    do_clear();
    send_frame(f1, -1, 2'b00, 1'b1, 1'b1);
    do_clear();

    for (int i = 0; i < 1000; i++) lr.push_back(1'($urandom_range(0, 1)));
    repeat (D) lr.push_back(1'b0);
    saw_norm = 1'b0;
    for (int i = 0; i < lr.size(); i++)
      step(1'b1, lr[i], (i % 20 == 10) ? (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10) : 2'b00, 1'b0, -1);
    check_val("norm_seen", saw_norm, 1);
    do_clear();

    for (int i = 0; i < 7; i++) step(1'b1, f1[i], 2'b00, 1'b0, 0);
    step(1'b1, f1[7], 2'b00, 1'b1, -1);
    send_frame(f2, -1, 2'b00, 1'b0, 1'b1);
    do_clear();

    for (int i = 0; i < 100; i++)
      step(1'b1, lr[i], (i % 20 == 10) ? 2'b01 : 2'b00, 1'b0, -1);
    RST_N = 1'b0;
    #1;
    check_val("mid_rst_out_valid", bus.out_valid, 0);
    check_val("mid_rst_out_bit", bus.out_bit, 0);
    check_val("mid_rst_best_metric", bus.best_metric, 0);
    reset_model();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    send_frame(f1, -1, 2'b00, 1'b0, 1'b1);
    check_val("sb_drained", exp_q.size(), D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
